// File: rtl/line_solver_engine_if.sv
// Beat stream between the option FIFO front-end and the line solver.
// master = FIFO side, slave = engine side.
interface line_solver_engine_if #(
  parameter int MAX_SIZE = 11
);
  logic                in_valid;
  logic                in_ready;
  logic [MAX_SIZE-1:0] option;
  logic                new_line;
  logic                put_back_to_FIFO;
  logic                put_back_valid;

  modport master (
    output in_valid, option,
    input  in_ready, new_line,
    input  put_back_to_FIFO, put_back_valid
  );

  modport slave (
    input  in_valid, option,
    output in_ready, new_line,
    output put_back_to_FIFO, put_back_valid
  );
endinterface

// File: rtl/line_solver_engine.sv
// Nonogram line solver: filters streamed options against the board and
// intersects survivors. Optional LINE_SOLVER_STATS_EN adds pass/drop counters.
module line_solver_engine #(
  parameter int MAX_SIZE = 11,
  parameter int CNT_W    = 7,
  parameter int IDX_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic started,
  input  logic [3:0] num_rows,
  input  logic [3:0] num_cols,
  input  logic [2*MAX_SIZE-1:0][CNT_W-1:0] old_options_amnt,
  line_solver_engine_if.slave bus,
  output logic [2*MAX_SIZE-1:0][CNT_W-1:0] new_options_amnt,
  output logic [MAX_SIZE*MAX_SIZE-1:0] known,
  output logic [MAX_SIZE*MAX_SIZE-1:0] assigned,
  output logic solved,
  output logic unsolvable,
  output logic stuck
`ifdef LINE_SOLVER_STATS_EN
  ,
  output logic [7:0]  pass_count,
  output logic [15:0] options_dropped
`endif
);

  localparam int NL = 2*MAX_SIZE;
  localparam int NC = MAX_SIZE*MAX_SIZE;

  typedef enum logic [2:0] {
    IDLE, HEADER, OPTS, COMMIT, DONE
  } state_t;

  state_t state;
  logic [3:0] rows_q, cols_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q, beat_q, surv_q;
  logic [MAX_SIZE-1:0] and_q, or_q;
  logic chg_q;

  logic [IDX_W-1:0] lines_n, col_idx, hdr_idx;
  logic is_row, hdr_ok, last_line;
  logic [3:0] len;
  logic [MAX_SIZE-1:0] len_mask, lk, la, line_new;
  logic keep, rose, solved_n, zero_cnt;
  logic [NC-1:0] nk, na, sm;

  assign lines_n   = IDX_W'(rows_q) + IDX_W'(cols_q);
  assign hdr_idx   = bus.option[IDX_W-1:0];
  assign hdr_ok    = hdr_idx < lines_n;
  assign is_row    = idx_q < IDX_W'(rows_q);
  assign col_idx   = idx_q - IDX_W'(rows_q);
  assign len       = is_row ? cols_q : rows_q;
  assign last_line = idx_q == lines_n - IDX_W'(1);

  // positions that belong to the current line
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_SIZE; i++)
      len_mask[i] = 4'(i) < len;
  end

  // board cells of the current line, in line order
  always_comb begin
    lk = '0;
    la = '0;
    for (int r = 0; r < MAX_SIZE; r++)
      for (int c = 0; c < MAX_SIZE; c++) begin
        if (is_row && idx_q == IDX_W'(r)) begin
          lk[c] = known[r*MAX_SIZE+c];
          la[c] = assigned[r*MAX_SIZE+c];
        end
        if (!is_row && col_idx == IDX_W'(c)) begin
          lk[r] = known[r*MAX_SIZE+c];
          la[r] = assigned[r*MAX_SIZE+c];
        end
      end
  end

  assign keep     = ~|(lk & (bus.option ^ la) & len_mask);
  assign line_new = (and_q | ~or_q) & len_mask & ~lk;
  assign rose     = |line_new;

  // board after committing the current line
  always_comb begin
    nk = known;
    na = assigned;
    for (int r = 0; r < MAX_SIZE; r++)
      for (int c = 0; c < MAX_SIZE; c++) begin
        if (is_row && idx_q == IDX_W'(r) && line_new[c]) begin
          nk[r*MAX_SIZE+c] = 1'b1;
          na[r*MAX_SIZE+c] = and_q[c];
        end
        if (!is_row && col_idx == IDX_W'(c) && line_new[r]) begin
          nk[r*MAX_SIZE+c] = 1'b1;
          na[r*MAX_SIZE+c] = and_q[r];
        end
      end
  end

  // cells inside the active puzzle area
  always_comb begin
    sm = '0;
    for (int r = 0; r < MAX_SIZE; r++)
      for (int c = 0; c < MAX_SIZE; c++)
        sm[r*MAX_SIZE+c] = (4'(r) < rows_q) && (4'(c) < cols_q);
  end

  assign solved_n = &(nk | ~sm);

  // an active line starting with no options can never be satisfied
  always_comb begin
    zero_cnt = 1'b0;
    for (int i = 0; i < NL; i++)
      if (IDX_W'(i) < IDX_W'(num_rows) + IDX_W'(num_cols) &&
          old_options_amnt[i] == '0)
        zero_cnt = 1'b1;
  end

  // control FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      rows_q               <= '0;
      cols_q               <= '0;
      idx_q                <= '0;
      cnt_q                <= '0;
      beat_q               <= '0;
      surv_q               <= '0;
      and_q                <= '0;
      or_q                 <= '0;
      chg_q                <= 1'b0;
      bus.in_ready         <= 1'b0;
      bus.new_line         <= 1'b0;
      bus.put_back_to_FIFO <= 1'b0;
      bus.put_back_valid   <= 1'b0;
      new_options_amnt     <= '0;
      known                <= '0;
      assigned             <= '0;
      solved               <= 1'b0;
      unsolvable           <= 1'b0;
      stuck                <= 1'b0;
`ifdef LINE_SOLVER_STATS_EN
      pass_count           <= '0;
      options_dropped      <= '0;
`endif
    end else begin
      bus.new_line         <= 1'b0;
      bus.put_back_valid   <= 1'b0;
      bus.put_back_to_FIFO <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (started) begin
            rows_q           <= num_rows;
            cols_q           <= num_cols;
            new_options_amnt <= old_options_amnt;
            known            <= '0;
            assigned         <= '0;
            solved           <= 1'b0;
            stuck            <= 1'b0;
            chg_q            <= 1'b0;
            unsolvable       <= zero_cnt;
            bus.in_ready     <= !zero_cnt;
            state            <= zero_cnt ? DONE : HEADER;
`ifdef LINE_SOLVER_STATS_EN
            pass_count       <= '0;
            options_dropped  <= '0;
`endif
          end
        end
        HEADER: begin
          if (bus.in_valid) begin
            bus.new_line <= 1'b1;
            if (hdr_ok) begin
              idx_q  <= hdr_idx;
              cnt_q  <= new_options_amnt[hdr_idx];
              beat_q <= '0;
              and_q  <= '1;
              or_q   <= '0;
              surv_q <= '0;
              state  <= OPTS;
            end
          end
        end
        OPTS: begin
          if (bus.in_valid) begin
            bus.put_back_valid   <= 1'b1;
            bus.put_back_to_FIFO <= keep;
            if (keep) begin
              and_q  <= and_q & bus.option;
              or_q   <= or_q | bus.option;
              surv_q <= surv_q + CNT_W'(1);
            end
`ifdef LINE_SOLVER_STATS_EN
            else if (options_dropped != '1)
              options_dropped <= options_dropped + 16'd1;
`endif
            beat_q <= beat_q + CNT_W'(1);
            if (beat_q == cnt_q - CNT_W'(1)) begin
              bus.in_ready <= 1'b0;
              state        <= COMMIT;
            end
          end
        end
        COMMIT: begin
`ifdef LINE_SOLVER_STATS_EN
          if (last_line && pass_count != 8'hff)
            pass_count <= pass_count + 8'd1;
`endif
          if (surv_q == '0) begin
            unsolvable <= 1'b1;
            state      <= DONE;
          end else begin
            known                   <= nk;
            assigned                <= na;
            new_options_amnt[idx_q] <= surv_q;
            if (solved_n) begin
              solved <= 1'b1;
              state  <= DONE;
            end else if (last_line && !(chg_q | rose)) begin
              stuck <= 1'b1;
              state <= DONE;
            end else begin
              chg_q        <= last_line ? 1'b0 : (chg_q | rose);
              bus.in_ready <= 1'b1;
              state        <= HEADER;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
